input_conditioner: RTL



---
 rtl/input_conditioner.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner
//   Board-input front end: brings raw push buttons and slide switches into the clk domain,
//   debounces every bit independently and delivers clean levels plus one-cycle edge events.
//   A small encoder turns button presses into a valid/code/collision triple for game FSMs.
//
// Ports
//   clk             system clock, all state updates on its rising edge
//   rst_n           synchronous active-low reset
//   btn_raw         raw push buttons, active-high, asynchronous to clk
//   sw_raw          raw slide switches, asynchronous to clk
//   btn_level       debounced button levels
//   sw_level        debounced switch levels
//   btn_rise        one-cycle pulse per button on an accepted 0->1 change
//   sw_rise         one-cycle pulse per switch on an accepted 0->1 change
//   sw_fall         one-cycle pulse per switch on an accepted 1->0 change
//   press_valid     one-cycle pulse when any btn_rise bit is set
//   press_code      index of the lowest-numbered rising button (qualified by press_valid)
//   press_collision one-cycle pulse when two or more buttons rise in the same cycle
//
// Pipeline for a clean edge sampled at posedge 0: synchronizer (posedges 0,1), debounce
// counter accepts at posedge 1+DEBOUNCE_CYCLES, output stage exposes the new level and its
// pulse at posedge 2+DEBOUNCE_CYCLES.

module input_conditioner #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned NUM_SW          = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_SW-1:0]  sw_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_SW-1:0]  sw_rise,
  output logic [NUM_SW-1:0]  sw_fall,
  output logic               press_valid,
  output logic [1:0]         press_code,
  output logic               press_collision
);

  // ---------------------------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------------------------
  if (NUM_BTN > 4) begin : g_chk_num_btn
    $error("input_conditioner: NUM_BTN > 4 cannot be encoded on press_code");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be 2 or more");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_cnt_w
    $error("input_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  // Buttons occupy the low bits of the combined vector, switches the high bits.
  localparam int unsigned NumIn = NUM_BTN + NUM_SW;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NumIn-1:0] raw_in;
  logic [NumIn-1:0] sync1_q;
  logic [NumIn-1:0] sync2_q;
  logic [NumIn-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NumIn];
  logic [CNT_W-1:0] cnt_d [NumIn];

  logic [NumIn-1:0]   level_q, level_d;
  logic [NumIn-1:0]   rise_q, rise_d;
  logic [NUM_SW-1:0]  fall_q, fall_d;
  logic [NUM_BTN-1:0] btn_rise_d;
  logic               press_valid_q, press_valid_d;
  logic [1:0]         press_code_q, press_code_d;
  logic               press_collision_q, press_collision_d;

  assign raw_in = {sw_raw, btn_raw};

  // ---------------------------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-bit debounce: a counter runs only while the synchronized bit disagrees with the
  // accepted value; any agreement (a bounce back) clears it. The counter stops at CntMax,
  // where the new value is taken, so it can never wrap.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NumIn); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < int'(NumIn); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < int'(NumIn); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output stage: the registered level trails the accepted value by one cycle, so an accepted
  // change shows up as (new accepted value) != (current output level). That difference is the
  // edge pulse, registered together with the level so both appear in the same cycle.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    level_d    = stable_q;
    rise_d     = stable_q & ~level_q;
    fall_d     = ~stable_q[NumIn-1:NUM_BTN] & level_q[NumIn-1:NUM_BTN];
    btn_rise_d = rise_d[NUM_BTN-1:0];
  end

  // Button encoder works on the same next-state rise vector, so it lines up with btn_rise.
  always_comb begin
    press_valid_d = |btn_rise_d;
    press_code_d  = 2'd0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
      if (btn_rise_d[i]) begin
        press_code_d = 2'(i);
      end
    end
    // Clearing the lowest set bit leaves something only if two or more were set.
    press_collision_d = (btn_rise_d & (btn_rise_d - NUM_BTN'(1))) != '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q           <= '0;
      rise_q            <= '0;
      fall_q            <= '0;
      press_valid_q     <= 1'b0;
      press_code_q      <= 2'd0;
      press_collision_q <= 1'b0;
    end else begin
      level_q           <= level_d;
      rise_q            <= rise_d;
      fall_q            <= fall_d;
      press_valid_q     <= press_valid_d;
      press_code_q      <= press_code_d;
      press_collision_q <= press_collision_d;
    end
  end

  assign btn_level       = level_q[NUM_BTN-1:0];
  assign sw_level        = level_q[NumIn-1:NUM_BTN];
  assign btn_rise        = rise_q[NUM_BTN-1:0];
  assign sw_rise         = rise_q[NumIn-1:NUM_BTN];
  assign sw_fall         = fall_q;
  assign press_valid     = press_valid_q;
  assign press_code      = press_code_q;
  assign press_collision = press_collision_q;

endmodule
